// File: rtl/cnn_accel_pkg.sv
// cnn_accel_pkg
//   Shared definitions for the dense-layer result server: FSM state
//   encoding, default logit/partial-sum counts and the per-logit bias
//   table loaded into the accumulators when a collection starts.
package cnn_accel_pkg;

    localparam int NUM_OUT_DEF  = 9;
    localparam int NUM_PART_DEF = 8;
    localparam int DENSE_BIAS_N = 9;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_READY   = 2'd2;

    localparam logic [31:0] DENSE_BIAS [0:DENSE_BIAS_N-1] = '{
        32'd0, 32'd16, 32'd32, 32'd48, 32'd64,
        32'd80, 32'd96, 32'd112, 32'd128
    };

    // Logits beyond the bias table start from zero.
    function automatic logic [31:0] bias_of(input int k);
        if (k >= 0 && k < DENSE_BIAS_N) return DENSE_BIAS[k];
        return '0;
    endfunction

endpackage

// File: rtl/dense_result_server_sat_add32.sv
// sat_add32
//   Combinational 32-bit two's-complement saturating adder.
//   Ports:
//     i_a, i_b : signed operands
//     o_sum    : a+b clamped to [0x80000000, 0x7FFFFFFF]
//     o_ovf    : high when the clamp was applied
module sat_add32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum,
    output logic        o_ovf
);

    logic [32:0] w_wide;

    assign w_wide = {i_a[31], i_a} + {i_b[31], i_b};
    // Overflow whenever the 33-bit sign disagrees with bit 31.
    assign o_ovf  = w_wide[32] ^ w_wide[31];
    assign o_sum  = !o_ovf     ? w_wide[31:0] :
                    w_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;

endmodule

// File: rtl/dense_result_server.sv
// dense_result_server
//   Collects NUM_OUT*NUM_PART signed partial sums (logit-major order),
//   accumulates them with saturation on top of a per-logit bias and then
//   serves the finished logits through a registered random-access read port.
//   A stall watchdog aborts a collection that goes TIMEOUT-1 cycles
//   without an accepted beat.
//   Ports:
//     clk, reset          : clock, async active-high reset
//     start               : begin a new collection (ignored while busy)
//     part_valid/data/ready : partial-sum stream, ready == busy
//     read_addr/read_data : logit read, one-cycle latency, 0 unless done
//     done, busy          : READY / COLLECT state indicators
//     timeout_err, sat_seen : sticky status of the last collection
module dense_result_server
    import cnn_accel_pkg::*;
#(
    parameter int NUM_OUT  = NUM_OUT_DEF,
    parameter int NUM_PART = NUM_PART_DEF,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        part_valid,
    input  logic [31:0] part_data,
    output logic        part_ready,
    input  logic [3:0]  read_addr,
    output logic [31:0] read_data,
    output logic        done,
    output logic        busy,
    output logic        timeout_err,
    output logic        sat_seen
);

    localparam int OUT_W   = (NUM_OUT  > 1) ? $clog2(NUM_OUT)  : 1;
    localparam int PART_W  = (NUM_PART > 1) ? $clog2(NUM_PART) : 1;
    localparam int STALL_W = (TIMEOUT  > 2) ? $clog2(TIMEOUT)  : 1;

    state_t             r_state;
    logic [31:0]        r_acc [NUM_OUT];
    logic [PART_W-1:0]  r_part_idx;
    logic [OUT_W-1:0]   r_out_idx;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_timeout_err;
    logic               r_sat_seen;
    logic [31:0]        r_read_data;

    logic        w_collect, w_beat, w_ovf;
    logic        w_last_part, w_last_out, w_stall_exp;
    logic [31:0] w_acc_cur, w_sum, w_rd_sel;

    assign w_collect   = (r_state == ST_COLLECT);
    assign w_beat      = part_valid && w_collect;
    assign w_last_part = (r_part_idx == PART_W'(NUM_PART - 1));
    assign w_last_out  = (r_out_idx == OUT_W'(NUM_OUT - 1));
    // Fires on the idle cycle that would take the counter to TIMEOUT-1.
    assign w_stall_exp = (r_stall_cnt == STALL_W'(TIMEOUT - 2));

    // Explicit muxes keep out-of-range indices harmless (they select 0).
    always_comb begin
        w_acc_cur = '0;
        w_rd_sel  = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (r_out_idx == OUT_W'(k)) w_acc_cur = r_acc[k];
            if (read_addr == 4'(k))     w_rd_sel  = r_acc[k];
        end
    end

    sat_add32 u_sat_add (
        .i_a   (w_acc_cur),
        .i_b   (part_data),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_part_idx    <= '0;
            r_out_idx     <= '0;
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
            r_sat_seen    <= 1'b0;
            r_read_data   <= '0;
            for (int k = 0; k < NUM_OUT; k++) r_acc[k] <= '0;
        end else begin
            r_read_data <= (r_state == ST_READY) ? w_rd_sel : '0;

            case (r_state)
                ST_IDLE, ST_READY: begin
                    if (start) begin
                        r_state       <= ST_COLLECT;
                        r_part_idx    <= '0;
                        r_out_idx     <= '0;
                        r_stall_cnt   <= '0;
                        r_timeout_err <= 1'b0;
                        r_sat_seen    <= 1'b0;
                        for (int k = 0; k < NUM_OUT; k++) r_acc[k] <= bias_of(k);
                    end
                end
                ST_COLLECT: begin
                    if (w_beat) begin
                        for (int k = 0; k < NUM_OUT; k++)
                            if (r_out_idx == OUT_W'(k)) r_acc[k] <= w_sum;
                        if (w_ovf) r_sat_seen <= 1'b1;
                        r_stall_cnt <= '0;
                        if (w_last_part) begin
                            r_part_idx <= '0;
                            if (w_last_out) begin
                                r_out_idx <= '0;
                                r_state   <= ST_READY;
                            end else begin
                                r_out_idx <= r_out_idx + OUT_W'(1);
                            end
                        end else begin
                            r_part_idx <= r_part_idx + PART_W'(1);
                        end
                    end else if (w_stall_exp) begin
                        // Aborted run: publish all-zero results with the error flag.
                        for (int k = 0; k < NUM_OUT; k++) r_acc[k] <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_READY;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign part_ready  = w_collect;
    assign busy        = w_collect;
    assign done        = (r_state == ST_READY);
    assign read_data   = r_read_data;
    assign timeout_err = r_timeout_err;
    assign sat_seen    = r_sat_seen;

endmodule
